// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key_debounce_array push-button front end:
//   - hold_state_e : per-channel hold/auto-repeat FSM states
//   - DEF_*        : default parameter values (50 MHz board, 1 ms sample tick)
//   - clog2_max    : counter width able to hold max(a, b) without wrapping
// ---------------------------------------------------------------------------
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD_DLY = 2'd1,
    ST_HOLD_RPT = 2'd2
  } hold_state_e;

  localparam int DEF_N_KEYS      = 4;
  localparam int DEF_TICK_DIV    = 50000;
  localparam int DEF_DEB_SAMPLES = 10;
  localparam int DEF_REPEAT_DLY  = 500;
  localparam int DEF_REPEAT_PER  = 100;
  localparam int DEF_ACTIVE_HIGH = 1;

  // Width of a counter that must represent values 0..max(a, b).
  function automatic int clog2_max(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// ---------------------------------------------------------------------------
// key_debounce_ch
// One key channel: two-flop synchroniser with polarity normalisation,
// tick-driven debounce counter, hold/auto-repeat FSM and registered outputs.
// Ports:
//   clk_i       : system clock
//   rst_i       : synchronous reset, active-high
//   tick_i      : shared one-cycle sample strobe
//   key_raw_i   : raw asynchronous key pin
//   repeat_en_i : auto-repeat enable (synchronous)
//   state_o     : debounced level, 1 = pressed
//   press_o     : one-cycle pulse on debounced press
//   release_o   : one-cycle pulse on debounced release
//   repeat_o    : one-cycle pulse per repeat interval while held
// ---------------------------------------------------------------------------
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEB_SAMPLES = DEF_DEB_SAMPLES,
  parameter int REPEAT_DLY  = DEF_REPEAT_DLY,
  parameter int REPEAT_PER  = DEF_REPEAT_PER,
  parameter int ACTIVE_HIGH = DEF_ACTIVE_HIGH
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic key_raw_i,
  input  logic repeat_en_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int DW = $clog2(DEB_SAMPLES + 1);
  localparam int HW = clog2_max(REPEAT_DLY, REPEAT_PER);

  localparam logic          INACTIVE = (ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;
  // Terminal values are compared before incrementing so the counters never
  // need to hold the target value itself and can never wrap.
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_SAMPLES - 1);
  localparam logic [HW-1:0] DLY_LAST = HW'(REPEAT_DLY - 1);
  localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PER - 1);

  logic          sync1_q, sync2_q;
  logic          sample_s;
  logic          flip_s;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  hold_state_e   st_q, st_d;
  logic          key_state_q, key_state_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;

  // Two-flop synchroniser; reset loads the inactive pin level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= INACTIVE;
      sync2_q <= INACTIVE;
    end else begin
      sync1_q <= key_raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign sample_s = (ACTIVE_HIGH != 0) ? sync2_q : ~sync2_q;

  // Debounce counter: counts consecutive ticks disagreeing with the current level.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    flip_s    = 1'b0;
    if (tick_i) begin
      if (sample_s != key_state_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          flip_s    = 1'b1;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end else begin
        deb_cnt_d = '0;
      end
    end else begin
      deb_cnt_d = deb_cnt_q;
    end
  end

  // Hold FSM and pulse generation; a debounced transition outranks repeats.
  always_comb begin
    st_d        = st_q;
    hold_cnt_d  = hold_cnt_q;
    key_state_d = key_state_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    repeat_d    = 1'b0;
    if (flip_s && !key_state_q) begin
      key_state_d = 1'b1;
      press_d     = 1'b1;
      st_d        = ST_HOLD_DLY;
      hold_cnt_d  = '0;
    end else if (flip_s && key_state_q) begin
      key_state_d = 1'b0;
      release_d   = 1'b1;
      st_d        = ST_IDLE;
      hold_cnt_d  = '0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          hold_cnt_d = '0;
        end
        ST_HOLD_DLY: begin
          if (!repeat_en_i) begin
            hold_cnt_d = '0;
          end else if (tick_i) begin
            if (hold_cnt_q == DLY_LAST) begin
              repeat_d   = 1'b1;
              st_d       = ST_HOLD_RPT;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + HW'(1);
            end
          end else begin
            hold_cnt_d = hold_cnt_q;
          end
        end
        ST_HOLD_RPT: begin
          // Disabling repeat drops back so re-enabling waits the full first delay.
          if (!repeat_en_i) begin
            hold_cnt_d = '0;
            st_d       = ST_HOLD_DLY;
          end else if (tick_i) begin
            if (hold_cnt_q == PER_LAST) begin
              repeat_d   = 1'b1;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + HW'(1);
            end
          end else begin
            hold_cnt_d = hold_cnt_q;
          end
        end
        default: begin
          st_d       = ST_IDLE;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      st_q        <= ST_IDLE;
      key_state_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      st_q        <= st_d;
      key_state_q <= key_state_d;
      press_q     <= press_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
    end
  end

  assign state_o   = key_state_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_debounce_array.sv
// ---------------------------------------------------------------------------
// key_debounce_array
// Multi-channel push-button front end: a shared sample-tick divider feeding
// N_KEYS independent debounce / hold-repeat channels.
// Ports:
//   CLK_50M     : system clock
//   RST         : synchronous reset, active-high
//   key_in      : raw asynchronous key pins
//   repeat_en   : per-channel auto-repeat enable
//   key_state   : debounced level, 1 = pressed
//   key_press   : one-cycle pulse on debounced press
//   key_release : one-cycle pulse on debounced release
//   key_repeat  : one-cycle pulse per repeat interval while held
//   tick        : one-cycle sample strobe
// ---------------------------------------------------------------------------
module key_debounce_array
  import key_pkg::*;
#(
  parameter int N_KEYS      = DEF_N_KEYS,
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int DEB_SAMPLES = DEF_DEB_SAMPLES,
  parameter int REPEAT_DLY  = DEF_REPEAT_DLY,
  parameter int REPEAT_PER  = DEF_REPEAT_PER,
  parameter int ACTIVE_HIGH = DEF_ACTIVE_HIGH
) (
  input  logic              CLK_50M,
  input  logic              RST,
  input  logic [N_KEYS-1:0] key_in,
  input  logic [N_KEYS-1:0] repeat_en,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat,
  output logic              tick
);

  localparam int            CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick_q;

  // Free-running divider, wraps after TICK_DIV-1.
  always_comb begin
    if (tick_cnt_q == TICK_LAST) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + CW'(1);
    end
  end

  // Tick is registered from the next count so it is high exactly while the count is TICK_DIV-1.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= (tick_cnt_d == TICK_LAST);
    end
  end

  assign tick = tick_q;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEB_SAMPLES (DEB_SAMPLES),
      .REPEAT_DLY  (REPEAT_DLY),
      .REPEAT_PER  (REPEAT_PER),
      .ACTIVE_HIGH (ACTIVE_HIGH)
    ) u_ch (
      .clk_i       (CLK_50M),
      .rst_i       (RST),
      .tick_i      (tick_q),
      .key_raw_i   (key_in[g]),
      .repeat_en_i (repeat_en[g]),
      .state_o     (key_state[g]),
      .press_o     (key_press[g]),
      .release_o   (key_release[g]),
      .repeat_o    (key_repeat[g])
    );
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// ---------------------------------------------------------------------------
// tb_key_debounce_array
// Directed bench: an active-high 2-key instance (TICK_DIV=4, DEB_SAMPLES=3,
// REPEAT_DLY=5, REPEAT_PER=2) and an active-low 1-key instance share clock
// and reset. Outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_key_debounce_array;

  logic       clk;
  logic       rst;
  logic [1:0] key_in, repeat_en;
  logic [1:0] key_state, key_press, key_release, key_repeat;
  logic       tick;
  logic [0:0] key_in_al, repeat_en_al;
  logic [0:0] state_al, press_al, release_al, repeat_al;
  logic       tick_al;

  int checks = 0;
  int errors = 0;

  key_debounce_array #(
    .N_KEYS(2), .TICK_DIV(4), .DEB_SAMPLES(3),
    .REPEAT_DLY(5), .REPEAT_PER(2), .ACTIVE_HIGH(1)
  ) dut (
    .CLK_50M(clk), .RST(rst), .key_in(key_in), .repeat_en(repeat_en),
    .key_state(key_state), .key_press(key_press), .key_release(key_release),
    .key_repeat(key_repeat), .tick(tick)
  );

  key_debounce_array #(
    .N_KEYS(1), .TICK_DIV(4), .DEB_SAMPLES(3),
    .REPEAT_DLY(5), .REPEAT_PER(2), .ACTIVE_HIGH(0)
  ) dut_al (
    .CLK_50M(clk), .RST(rst), .key_in(key_in_al), .repeat_en(repeat_en_al),
    .key_state(state_al), .key_press(press_al), .key_release(release_al),
    .key_repeat(repeat_al), .tick(tick_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the falling edge one cycle after the next tick, where that
  // tick's debounce/FSM results are visible.
  task automatic post_tick();
    int n;
    n = 0;
    @(negedge clk);
    while (tick !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("tick_timeout", {31'd0, tick}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    key_in       = 2'b00;
    repeat_en    = 2'b00;
    key_in_al    = 1'b1;
    repeat_en_al = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state",   {30'd0, key_state},   32'd0);
    chk("rst_press",   {30'd0, key_press},   32'd0);
    chk("rst_release", {30'd0, key_release}, 32'd0);
    chk("rst_repeat",  {30'd0, key_repeat},  32'd0);
    chk("rst_tick",    {31'd0, tick},        32'd0);
    chk("rst_al_state", {31'd0, state_al},   32'd0);
    rst = 1'b0;

    // Tick period: one strobe every 4 cycles.
    post_tick();
    chk("tick_ph0", {31'd0, tick}, 32'd0);
    @(negedge clk); chk("tick_ph1", {31'd0, tick}, 32'd0);
    @(negedge clk); chk("tick_ph2", {31'd0, tick}, 32'd0);
    @(negedge clk); chk("tick_ph3", {31'd0, tick}, 32'd1);
    @(negedge clk);
    post_tick();
    chk("al_idle_state", {31'd0, state_al}, 32'd0);
    chk("al_idle_press", {31'd0, press_al}, 32'd0);

    // Clean press on ch0 (and active-low key pulled low).
    key_in[0] = 1'b1;
    key_in_al = 1'b0;
    post_tick();
    chk("press_t1_state", {31'd0, key_state[0]}, 32'd0);
    chk("al_t1_state",    {31'd0, state_al},     32'd0);
    post_tick();
    chk("press_t2_state", {31'd0, key_state[0]}, 32'd0);
    post_tick();
    chk("press_t3_state",   {31'd0, key_state[0]},   32'd1);
    chk("press_t3_press",   {31'd0, key_press[0]},   32'd1);
    chk("press_t3_release", {31'd0, key_release[0]}, 32'd0);
    chk("press_t3_ch1",     {31'd0, key_press[1]},   32'd0);
    chk("al_t3_state",      {31'd0, state_al},       32'd1);
    chk("al_t3_press",      {31'd0, press_al},       32'd1);
    @(negedge clk);
    chk("press_pulse_end", {31'd0, key_press[0]}, 32'd0);
    chk("press_hold",      {31'd0, key_state[0]}, 32'd1);
    chk("al_pulse_end",    {31'd0, press_al},     32'd0);

    // Release ch0.
    key_in[0] = 1'b0;
    key_in_al = 1'b1;
    post_tick();
    post_tick();
    chk("rel_t2_state", {31'd0, key_state[0]}, 32'd1);
    post_tick();
    chk("rel_t3_state",   {31'd0, key_state[0]},   32'd0);
    chk("rel_t3_release", {31'd0, key_release[0]}, 32'd1);
    chk("rel_t3_press",   {31'd0, key_press[0]},   32'd0);
    chk("al_rel_release", {31'd0, release_al},     32'd1);
    @(negedge clk);
    chk("rel_pulse_end", {31'd0, key_release[0]}, 32'd0);

    // Glitch: high for 2 ticks only.
    key_in[0] = 1'b1;
    post_tick();
    post_tick();
    key_in[0] = 1'b0;
    post_tick();
    chk("glitch_state", {31'd0, key_state[0]}, 32'd0);
    chk("glitch_press", {31'd0, key_press[0]}, 32'd0);
    post_tick();
    chk("glitch_state2", {31'd0, key_state[0]}, 32'd0);
    // Counter must have cleared: a new press again needs all 3 ticks.
    key_in[0] = 1'b1;
    post_tick();
    chk("glitch_cnt_t1", {31'd0, key_state[0]}, 32'd0);
    post_tick();
    chk("glitch_cnt_t2", {31'd0, key_state[0]}, 32'd0);
    post_tick();
    chk("glitch_cnt_t3", {31'd0, key_press[0]}, 32'd1);
    key_in[0] = 1'b0;
    repeat (3) post_tick();
    chk("glitch_rel", {31'd0, key_release[0]}, 32'd1);

    // Auto-repeat on ch1.
    repeat_en[1] = 1'b1;
    key_in[1]    = 1'b1;
    repeat (3) post_tick();
    chk("rpt_press",    {31'd0, key_press[1]},  32'd1);
    chk("rpt_press_rp", {31'd0, key_repeat[1]}, 32'd0);
    for (int k = 1; k <= 12; k++) begin
      post_tick();
      chk($sformatf("rpt_k%0d", k), {31'd0, key_repeat[1]},
          ((k >= 5) && (k % 2 == 1)) ? 32'd1 : 32'd0);
    end
    key_in[1] = 1'b0;
    post_tick();
    chk("rpt_k13", {31'd0, key_repeat[1]}, 32'd1);
    post_tick();
    chk("rpt_k14", {31'd0, key_repeat[1]}, 32'd0);
    post_tick();
    chk("rpt_rel_release", {31'd0, key_release[1]}, 32'd1);
    chk("rpt_rel_repeat",  {31'd0, key_repeat[1]},  32'd0);
    chk("rpt_rel_state",   {31'd0, key_state[1]},   32'd0);
    @(negedge clk);
    chk("rpt_rel_end", {31'd0, key_release[1]}, 32'd0);

    // Repeat gating: held with repeat disabled, then enabled.
    repeat_en[1] = 1'b0;
    key_in[1]    = 1'b1;
    repeat (3) post_tick();
    chk("gate_press", {31'd0, key_press[1]}, 32'd1);
    for (int j = 1; j <= 10; j++) begin
      post_tick();
      chk($sformatf("gate_off_%0d", j), {31'd0, key_repeat[1]}, 32'd0);
    end
    repeat_en[1] = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      post_tick();
      chk($sformatf("gate_on_%0d", j), {31'd0, key_repeat[1]}, (j == 5) ? 32'd1 : 32'd0);
    end
    repeat_en[1] = 1'b0;
    key_in[1]    = 1'b0;
    repeat (3) post_tick();
    chk("gate_rel", {31'd0, key_release[1]}, 32'd1);

    // Reset while in HOLD_RPT with key still held.
    repeat_en[1] = 1'b1;
    key_in[1]    = 1'b1;
    repeat (3) post_tick();
    chk("mid_press", {31'd0, key_press[1]}, 32'd1);
    repeat (6) post_tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_state",   {30'd0, key_state},   32'd0);
    chk("mid_rst_press",   {30'd0, key_press},   32'd0);
    chk("mid_rst_release", {30'd0, key_release}, 32'd0);
    chk("mid_rst_repeat",  {30'd0, key_repeat},  32'd0);
    chk("mid_rst_tick",    {31'd0, tick},        32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_after_pulses", {26'd0, key_press, key_release, key_repeat}, 32'd0);
    post_tick();
    chk("mid_t1_state", {31'd0, key_state[1]}, 32'd0);
    post_tick();
    chk("mid_t2_state", {31'd0, key_state[1]}, 32'd0);
    post_tick();
    chk("mid_t3_state", {31'd0, key_state[1]}, 32'd1);
    chk("mid_t3_press", {31'd0, key_press[1]}, 32'd1);

    key_in[1] = 1'b0;
    repeat (3) post_tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce_array.md
Name: key_debounce_array

Overview:
- Parametrised multi-channel push-button front end, the successor to the 4-key fixed press detector.
- Synchronises N raw key inputs and debounces them on a shared sample tick.
- Emits a clean level, one-cycle press and release pulses, and optional hold-to-repeat pulses per key.
- Sits between board buttons and game/control logic, all in the 50 MHz domain.

Parameters:
N_KEYS, 4, number of independent key channels
TICK_DIV, 50000, clocks per sample tick (1 ms at 50 MHz); must be >= 2
DEB_SAMPLES, 10, consecutive opposite-level ticks needed to flip debounced state; must be >= 1
REPEAT_DLY, 500, ticks from debounced press to first repeat pulse; must be >= 1
REPEAT_PER, 100, ticks between subsequent repeat pulses; must be >= 1
ACTIVE_HIGH, 1, 1: key pressed when input = 1; 0: pressed when input = 0

Ports:
CLK_50M  in  1  system clock
RST  in  1  synchronous reset, active-high
key_in  in  N_KEYS  raw asynchronous key pins
repeat_en  in  N_KEYS  per-channel auto-repeat enable (synchronous)
key_state  out  N_KEYS  debounced level, 1 = pressed
key_press  out  N_KEYS  one-cycle pulse on debounced press
key_release  out  N_KEYS  one-cycle pulse on debounced release
key_repeat  out  N_KEYS  one-cycle pulse per repeat interval while held
tick  out  1  one-cycle sample strobe, exported for debug/bench use

Behaviour:
- Reset (RST high at a CLK_50M edge):
  - All outputs go to 0.
  - Tick counter goes to 0.
  - Synchroniser flops load the inactive level (ACTIVE_HIGH ? 0 : 1).
  - All per-channel counters clear; every FSM returns to IDLE.
  - Reset asserted mid-debounce or mid-hold aborts it. No pulse is emitted on the reset cycle or the cycle after.
- Synchroniser:
  - Two flops per channel, then polarity normalisation to pressed = 1.
  - Raw-to-sampled latency: 2 clocks.
- Tick:
  - Counter runs 0..TICK_DIV-1, then wraps to 0.
  - tick = 1 for exactly the one cycle in which the counter equals TICK_DIV-1. Free-running.
- Debounce, per channel, evaluated only on tick cycles:
  - Sample differs from key_state: deb_cnt increments.
  - Sample equals key_state: deb_cnt clears to 0.
  - When the increment would reach DEB_SAMPLES: key_state toggles and deb_cnt clears.
  - Outputs are registered. key_state and the matching press/release pulse change on the clock edge ending the tick cycle, i.e. visible the cycle after tick.
- Per-channel FSM, states IDLE, HOLD_DLY, HOLD_RPT:
  - IDLE -> HOLD_DLY on debounced press. key_press pulses; hold_cnt := 0.
  - HOLD_DLY: on each tick with repeat_en=1, hold_cnt increments. When it reaches REPEAT_DLY, pulse key_repeat, go to HOLD_RPT, hold_cnt := 0.
  - HOLD_RPT: on each tick with repeat_en=1, hold_cnt increments. When it reaches REPEAT_PER, pulse key_repeat, hold_cnt := 0.
  - Any held state -> IDLE on debounced release. key_release pulses; no key_repeat that cycle (release wins).
  - repeat_en=0 in a held state: hold_cnt forced to 0 and state forced to HOLD_DLY. Re-enabling restarts the full REPEAT_DLY.
- Counter widths:
  - deb_cnt: $clog2(DEB_SAMPLES+1).
  - hold_cnt: $clog2(max(REPEAT_DLY,REPEAT_PER)+1).
  - Neither counter may wrap.
- Pulse rules:
  - key_press and key_release are never high in the same cycle on one channel.
  - Each debounced transition yields exactly one pulse.
  - Channels are fully independent; simultaneous events on different channels produce simultaneous pulses.
- Glitches shorter than DEB_SAMPLES ticks produce no output change.

Decomposition:
- Package key_pkg holds:
  - hold-FSM state enum (IDLE, HOLD_DLY, HOLD_RPT);
  - default parameter constants;
  - a clog2-of-max helper function.
- Sub-module key_debounce_ch contains one channel: synchroniser, deb_cnt, hold FSM and output registers.
- The top holds the shared tick divider and a generate loop over N_KEYS.

Test Plan:
Test parameters: N_KEYS=2, TICK_DIV=4, DEB_SAMPLES=3, REPEAT_DLY=5, REPEAT_PER=2, ACTIVE_HIGH=1.
- Clean press: key_in[0] 0->1 held -> key_state[0]=1 and one key_press[0] pulse on the 3rd tick after the synchronised edge; key_release[0] stays 0.
- Glitch: key_in[0] high for 2 ticks then low -> no key_state/press change; deb_cnt returns to 0.
- Auto-repeat: key_in[1] held 20 ticks, repeat_en[1]=1 -> 1 press, then repeats at ticks 5, 7, 9, 11... after press; release gives exactly 1 key_release, no repeat on that cycle.
- Repeat gating: hold with repeat_en=0 for 10 ticks, then set to 1 -> first repeat exactly 5 ticks after enable.
- Active-low build (ACTIVE_HIGH=0): key_in idle at 1, pulled to 0 -> key_state=1 with same timing; RST idle yields no spurious press.
- Reset mid-hold: RST pulsed during HOLD_RPT -> all outputs 0 next cycle. If the key is still held after reset, a fresh press pulse comes DEB_SAMPLES ticks later.
